// File: rtl/mem_stat_scanner_if.sv
// mem_stat_scanner_if: request, result and memory-read signals of the range statistics scanner.
`default_nettype none

interface mem_stat_scanner_if;
  logic       Start;
  logic [7:0] Base_addr;
  logic [7:0] Count;
  logic [7:0] Mem_addr;
  logic       Mem_we;
  logic [7:0] Mem_data;
  logic [7:0] Max_out;
  logic [7:0] Min_out;
  logic [7:0] Avg_out;
  logic       Busy;
  logic       Done;

  modport master (
    output Start, Base_addr, Count, Mem_data,
    input  Mem_addr, Mem_we, Max_out, Min_out, Avg_out, Busy, Done
  );

  modport slave (
    input  Start, Base_addr, Count, Mem_data,
    output Mem_addr, Mem_we, Max_out, Min_out, Avg_out, Busy, Done
  );
endinterface

`default_nettype wire

// File: rtl/mem_stat_scanner.sv
// mem_stat_scanner: scans Count bytes of a registered-read memory and reports max, min and average.
// Optional macro STAT_ROUND_EN: round the average half-up instead of truncating.
`default_nettype none

module mem_stat_scanner (
  input  wire logic         CLK,
  input  wire logic         Reset_n,
  mem_stat_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  addr;
  logic [7:0]  count_lat;
  logic [7:0]  remaining;
  logic        first_beat;
  logic [7:0]  max_acc;
  logic [7:0]  min_acc;
  logic [15:0] sum;
  logic [15:0] quo;
  logic [7:0]  rem;
  logic [3:0]  iter;
  logic [7:0]  max_q;
  logic [7:0]  min_q;
  logic [7:0]  avg_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] sum_next;
  logic [15:0] div_seed;
  logic [8:0]  rem_shift;
  logic        rem_ge;
  logic [7:0]  rem_diff;

  always_comb begin
    sum_next = sum + {8'd0, bus.Mem_data};
`ifdef STAT_ROUND_EN
    div_seed = sum_next + {9'd0, count_lat[7:1]};
`else
    div_seed = sum_next;
`endif
    rem_shift = {rem, quo[15]};
    rem_ge    = (rem_shift >= {1'b0, count_lat});
    // When rem_shift >= divisor the true difference is below 256, so 8-bit wrap is exact.
    rem_diff  = rem_shift[7:0] - count_lat;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      addr       <= 8'd0;
      count_lat  <= 8'd0;
      remaining  <= 8'd0;
      first_beat <= 1'b0;
      max_acc    <= 8'd0;
      min_acc    <= 8'd0;
      sum        <= 16'd0;
      quo        <= 16'd0;
      rem        <= 8'd0;
      iter       <= 4'd0;
      max_q      <= 8'd0;
      min_q      <= 8'd0;
      avg_q      <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            count_lat <= bus.Count;
            if (bus.Count != 8'd0) begin
              addr       <= bus.Base_addr;
              remaining  <= bus.Count;
              first_beat <= 1'b1;
              max_acc    <= 8'h00;
              min_acc    <= 8'hFF;
              sum        <= 16'd0;
              busy_q     <= 1'b1;
              state      <= SCAN;
            end else begin
              state <= FIN;
            end
          end
        end

        SCAN: begin
          addr <= addr + 8'd1;
          // The first SCAN edge only presents Base_addr to memory; data arrives one edge later.
          if (first_beat) begin
            first_beat <= 1'b0;
          end else begin
            if (bus.Mem_data > max_acc) max_acc <= bus.Mem_data;
            if (bus.Mem_data < min_acc) min_acc <= bus.Mem_data;
            sum       <= sum_next;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              quo   <= div_seed;
              rem   <= 8'd0;
              iter  <= 4'd0;
              state <= DIV;
            end
          end
        end

        DIV: begin
          quo  <= {quo[14:0], rem_ge};
          rem  <= rem_ge ? rem_diff : rem_shift[7:0];
          iter <= iter + 4'd1;
          if (iter == 4'd15) begin
            busy_q <= 1'b0;
            state  <= FIN;
          end
        end

        FIN: begin
          if (count_lat == 8'd0) begin
            max_q <= 8'd0;
            min_q <= 8'd0;
            avg_q <= 8'd0;
          end else begin
            max_q <= max_acc;
            min_q <= min_acc;
            avg_q <= quo[7:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Mem_addr = addr;
  assign bus.Mem_we   = 1'b0;
  assign bus.Max_out  = max_q;
  assign bus.Min_out  = min_q;
  assign bus.Avg_out  = avg_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stat_scanner.sv
// tb_mem_stat_scanner: randomized + directed scoreboard bench for mem_stat_scanner.
`default_nettype none

module tb_mem_stat_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_stat_scanner_if bus();

  mem_stat_scanner dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory model.
  logic [7:0] mem [0:255];
  always @(posedge clk) bus.Mem_data <= mem[bus.Mem_addr];

  typedef struct {
    int         done_cyc;
    logic [7:0] mx;
    logic [7:0] mn;
    logic [7:0] av;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   free_after = -1;
  int   busy_lo = 1, busy_hi = 0;
  int   addr_lo = 1, addr_hi = 0;
  logic [7:0] addr_base = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: statistics straight from the definition over a modular address range.
  function automatic exp_t model(input logic [7:0] base, input logic [7:0] cnt);
    exp_t e;
    int mx, mn, sum, a;
    mx = 0; mn = 255; sum = 0;
    for (int i = 0; i < cnt; i++) begin
      a = (base + i) % 256;
      if (mem[a] > mx) mx = mem[a];
      if (mem[a] < mn) mn = mem[a];
      sum += mem[a];
    end
    e.done_cyc = 0;
    if (cnt == 0) begin
      e.mx = 8'd0; e.mn = 8'd0; e.av = 8'd0;
    end else begin
`ifdef STAT_ROUND_EN
      sum += cnt / 2;
`endif
      e.mx = 8'(mx); e.mn = 8'(mn); e.av = 8'(sum / cnt);
    end
    return e;
  endfunction

  task automatic issue(input logic [7:0] base, input logic [7:0] cnt);
    exp_t e;
    int k, lat;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Base_addr = base;
    bus.Count = cnt;
    k = cyc + 1;
    if (k > free_after) begin
      lat = (cnt == 0) ? 1 : cnt + 18;
      e = model(base, cnt);
      e.done_cyc = k + lat;
      sb.push_back(e);
      free_after = k + lat;
      if (cnt != 0) begin
        busy_lo = k; busy_hi = k + cnt + 16;
        addr_lo = k; addr_hi = k + cnt; addr_base = base;
      end
    end
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || cyc <= free_after) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL wait_idle: timeout with %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_max", bus.Max_out, 0);
    chk("rst_min", bus.Min_out, 0);
    chk("rst_avg", bus.Avg_out, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_addr", bus.Mem_addr, 0);
    sb.delete();
    free_after = -1;
    busy_lo = 1; busy_hi = 0; addr_lo = 1; addr_hi = 0;
    held.mx = 8'd0; held.mn = 8'd0; held.av = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: Busy/Mem_addr windows every cycle, result hold, scoreboard pop on Done.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", bus.Busy, int'(cyc >= busy_lo && cyc <= busy_hi));
      chk("mem_we", bus.Mem_we, 0);
      if (cyc >= addr_lo && cyc <= addr_hi)
        chk("mem_addr", bus.Mem_addr, int'(8'(addr_base + 8'(cyc - addr_lo))));
      if (bus.Done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected at cycle %0d: got Done=1 expected Done=0", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("max", bus.Max_out, e.mx);
          chk("min", bus.Min_out, e.mn);
          chk("avg", bus.Avg_out, e.av);
          held = e;
        end
      end else begin
        chk("hold_max", bus.Max_out, held.mx);
        chk("hold_min", bus.Min_out, held.mn);
        chk("hold_avg", bus.Avg_out, held.av);
      end
    end
  end

  initial begin
    int b, c;
    held.done_cyc = 0; held.mx = 8'd0; held.mn = 8'd0; held.av = 8'd0;
    bus.Start = 1'b0; bus.Base_addr = 8'd0; bus.Count = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    issue(8'd0, 8'd4);
    wait_idle();

    mem[5] = 8'd1; mem[6] = 8'd2;
    issue(8'd5, 8'd2);
    wait_idle();

    mem[254] = 8'd7; mem[255] = 8'd3; mem[0] = 8'd9; mem[1] = 8'd5;
    issue(8'd254, 8'd4);
    wait_idle();

    issue(8'd17, 8'd0);
    wait_idle();

    for (int i = 0; i < 256; i++) mem[i] = 8'd255;
    issue(8'd0, 8'd255);
    wait_idle();

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    issue(8'd0, 8'd10);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (40) @(negedge clk);
    issue(8'd3, 8'd6);
    wait_idle();

    issue(8'd10, 8'd8);
    repeat (3) @(negedge clk);
    issue(8'd50, 8'd3);
    repeat (10) @(negedge clk);
    issue(8'd90, 8'd0);
    wait_idle();

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      b = $urandom_range(0, 255);
      c = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      issue(8'(b), 8'(c));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stat_scanner.md
MEM_STAT_SCANNER -- requirements
Module: mem_stat_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL change on the rising edge of CLK, except reset.
REQ-002 The ports SHALL be:
- CLK  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  single-cycle request to begin a scan
- Base_addr  in  8  first memory address to scan
- Count  in  8  number of bytes to scan (0..255)
- Mem_addr  out  8  read address driven to the Memory Address_in
- Mem_data  in  8  Memory Data_out
- Max_out  out  8  maximum byte in the range
- Min_out  out  8  minimum byte in the range
- Avg_out  out  8  average of the range (sum / Count)
- Busy  out  1  high while a scan or divide is in progress
- Done  out  1  one-cycle pulse when results are valid

Function
REQ-003 The block SHALL never write memory; the Memory write enable SHALL be held at 0 at the top level.
REQ-004 Memory read timing SHALL be as follows: Mem_data reflects the Mem_addr value that was present at the previous CLK rising edge (one-cycle registered read).
REQ-005 The state machine SHALL have states IDLE, SCAN, DIV and FIN.
REQ-006 In IDLE, Start=1 at an edge with Count!=0 SHALL latch Base_addr and Count, set Mem_addr=Base_addr, clear the accumulators (Max=0x00, Min=0xFF, Sum=0), and enter SCAN.
REQ-007 In IDLE, Start=1 with Count=0 SHALL go straight to FIN with Max_out, Min_out and Avg_out all equal to 0.
REQ-008 In SCAN, Mem_addr SHALL increment by 1 on each edge, modulo 256; 0xFF wraps to 0x00.
REQ-009 In SCAN, starting on the second edge after Start, Mem_data SHALL be captured on each of Count consecutive edges:
- Max and Min update by unsigned compare.
- Sum (16-bit, unsigned) accumulates.
REQ-010 After the Count-th capture, the block SHALL enter DIV and run a 16-iteration restoring division Sum/Count_latched, one quotient bit per cycle.
REQ-011 The quotient SHALL always fit in 8 bits; Avg_out SHALL be the low 8 quotient bits.
REQ-012 After DIV the block SHALL enter FIN, update Max_out, Min_out and Avg_out, and assert Done for exactly one cycle, then return to IDLE.
REQ-013 Done SHALL rise exactly Count+18 cycles after the Start-accepting edge for Count!=0, and 1 cycle after it for Count=0.
REQ-014 Busy SHALL be 1 in SCAN and DIV, and 0 in IDLE and FIN.
REQ-015 Start while Busy=1 SHALL be ignored.
REQ-016 Outputs SHALL hold their last results until the next FIN.
REQ-017 Max_out, Min_out and Avg_out SHALL NOT change during SCAN or DIV.

Reset
REQ-018 Reset_n=0 SHALL immediately force:
- state IDLE
- Mem_addr=0, Max_out=0, Min_out=0, Avg_out=0
- Busy=0, Done=0
- internal accumulators and divider cleared
REQ-019 Reset asserted mid-scan or mid-divide SHALL abort the operation with no Done pulse.
REQ-020 The first Start after reset release SHALL behave as in REQ-006.

Configuration
REQ-021 Macro STAT_ROUND_EN SHALL control average rounding.
- Defined: before DIV, Sum SHALL be replaced by Sum + (Count>>1), giving round-half-up. The maximum value, 65152, fits in 16 bits.
- Undefined: Avg_out SHALL be the truncated floor(Sum/Count).
- Latency SHALL be identical in both builds.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Memory[0..3]=10,20,30,40; Base=0; Count=4 -> Max=40, Min=10, Avg=25; Done 22 cycles after Start.
- Memory[5..6]=1,2; Base=5; Count=2 -> Avg=2 with STAT_ROUND_EN, Avg=1 without; Max=2, Min=1.
- Base=254, Count=4, Memory[254,255,0,1]=7,3,9,5 -> Mem_addr sequence 254,255,0,1; Max=9, Min=3, Avg=6.
- Count=0 -> Done 1 cycle after Start; Max=Min=Avg=0; Busy never high.
- All 256 locations=255; Base=0; Count=255 -> Max=Min=Avg=255; no Sum overflow.
- Reset_n pulsed low during SCAN -> all outputs 0, IDLE, no Done. A Start issued while Busy -> ignored, and the original results are unchanged.
